// File: rtl/aq_hpcp_cnt.sv
// aq_hpcp_cnt: selected-event capture and 64-bit mhpmcounter increment.
// Define AQ_HPCP_OVF_EN to add the sticky wrap flag and its clear input.
module aq_hpcp_cnt #(
    parameter int HPMCNT_NUM   = 42,
    parameter int HPMEVT_WIDTH = 6
) (
    input  logic                  eventx_clk,
    input  logic                  cpurst_b,
    input  logic [63:0]           eventx_value,
    input  logic [HPMCNT_NUM-1:0] hpcp_event_bus,
    input  logic                  cntx_inhibit,
    input  logic                  cntx_wen,
    input  logic [63:0]           hpcp_wdata,
`ifdef AQ_HPCP_OVF_EN
    input  logic                  cntx_ovf_clr,
    output logic                  cntx_ovf,
`endif
    output logic [63:0]           cntx_value,
    output logic                  cntx_clk_en
);

    logic [HPMEVT_WIDTH-1:0] sel;
    logic                    hit_raw;
    logic                    hit_q;
    logic [63:0]             value;
    logic                    unused_sel_hi;

    assign sel           = eventx_value[HPMEVT_WIDTH-1:0];
    assign unused_sel_hi = ^eventx_value[63:HPMEVT_WIDTH];

    // Code 0 and codes above HPMCNT_NUM match nothing and never count.
    always_comb begin
        hit_raw = 1'b0;
        for (int i = 1; i <= HPMCNT_NUM; i++) begin
            if (sel == HPMEVT_WIDTH'(i)) begin
                hit_raw = hpcp_event_bus[i-1];
            end
        end
    end

    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_raw & ~cntx_inhibit & ~cntx_wen;
        end
    end

    // A write overrides a pending hit; that increment is dropped.
    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            value <= 64'd0;
        end else if (cntx_wen) begin
            value <= hpcp_wdata;
        end else if (hit_q) begin
            value <= value + 64'd1;
        end
    end

    assign cntx_value = value;

`ifdef AQ_HPCP_OVF_EN
    logic wrap;
    logic ovf_q;

    assign wrap = hit_q & ~cntx_wen & (value == {64{1'b1}});

    always_ff @(posedge eventx_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ovf_q <= 1'b0;
        end else if (wrap) begin
            ovf_q <= 1'b1;
        end else if (cntx_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign cntx_ovf    = ovf_q;
    assign cntx_clk_en = hit_raw | hit_q | cntx_wen | cntx_ovf_clr;
`else
    assign cntx_clk_en = hit_raw | hit_q | cntx_wen;
`endif

endmodule

// File: tb/tb_aq_hpcp_cnt.sv
// tb_aq_hpcp_cnt: directed scoreboard bench for the per-counter stage.
// Expected values are queued at drive time and popped after each edge.
module tb_aq_hpcp_cnt;

    localparam int N = 42;

    logic          eventx_clk = 1'b0;
    logic          cpurst_b   = 1'b0;
    logic [63:0]   eventx_value = 64'd0;
    logic [N-1:0]  bus   = '0;
    logic          inh   = 1'b0;
    logic          wen   = 1'b0;
    logic [63:0]   wdata = 64'd0;
    logic          ovf_clr = 1'b0;
    logic [63:0]   cntx_value;
    logic          cntx_clk_en;
`ifdef AQ_HPCP_OVF_EN
    logic          cntx_ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic          m_hitq = 1'b0;
    logic [63:0]   m_val  = 64'd0;
    logic          m_ovf  = 1'b0;
    logic [63:0]   sb_q[$];

    aq_hpcp_cnt #(.HPMCNT_NUM(N), .HPMEVT_WIDTH(6)) dut (
        .eventx_clk     (eventx_clk),
        .cpurst_b       (cpurst_b),
        .eventx_value   (eventx_value),
        .hpcp_event_bus (bus),
        .cntx_inhibit   (inh),
        .cntx_wen       (wen),
        .hpcp_wdata     (wdata),
`ifdef AQ_HPCP_OVF_EN
        .cntx_ovf_clr   (ovf_clr),
        .cntx_ovf       (cntx_ovf),
`endif
        .cntx_value     (cntx_value),
        .cntx_clk_en    (cntx_clk_en)
    );

    always #5 eventx_clk = ~eventx_clk;

    function automatic logic raw_of(logic [63:0] ev, logic [N-1:0] b);
        int s;
        s = int'(ev[5:0]);
        if (s >= 1 && s <= N) return b[s-1];
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        logic        r;
        logic        en;
        logic        nh;
        logic        no;
        logic [63:0] nv;
        #1;
        r  = raw_of(eventx_value, bus);
        en = r | m_hitq | wen;
`ifdef AQ_HPCP_OVF_EN
        en = en | ovf_clr;
`endif
        chk("clk_en", {63'd0, cntx_clk_en}, {63'd0, en});
        no = m_ovf;
        if (wen) nv = wdata;
        else if (m_hitq) nv = m_val + 64'd1;
        else nv = m_val;
        if (!wen && m_hitq && m_val == {64{1'b1}}) no = 1'b1;
        else if (ovf_clr) no = 1'b0;
        nh = r & ~inh & ~wen;
        sb_q.push_back(nv);
        @(posedge eventx_clk);
        m_val  = nv;
        m_hitq = nh;
        m_ovf  = no;
        @(negedge eventx_clk);
        chk("value", cntx_value, sb_q.pop_front());
`ifdef AQ_HPCP_OVF_EN
        chk("ovf", {63'd0, cntx_ovf}, {63'd0, m_ovf});
`endif
    endtask

    initial begin
        @(negedge eventx_clk);
        @(negedge eventx_clk);
        chk("reset_value", cntx_value, 64'd0);
        chk("reset_clk_en", {63'd0, cntx_clk_en}, 64'd0);
        cpurst_b = 1'b1;
        tick();

        // Three back-to-back pulses on event 5.
        eventx_value = 64'd5;
        bus[4] = 1'b1;
        tick();
        chk("lat_not_yet", cntx_value, 64'd0);
        tick();
        chk("cnt1", cntx_value, 64'd1);
        tick();
        chk("cnt2", cntx_value, 64'd2);
        bus = '0;
        tick();
        chk("cnt3", cntx_value, 64'd3);
        tick();
        tick();
        chk("cnt_hold", cntx_value, 64'd3);

        // Select 0, then an out-of-range select, with a noisy bus.
        eventx_value = 64'hFFFF_0000_0000_0000;
        for (int i = 0; i < 10; i++) begin
            bus = N'({$urandom(), $urandom()});
            tick();
        end
        eventx_value = 64'd43;
        for (int i = 0; i < 10; i++) begin
            bus = N'({$urandom(), $urandom()});
            tick();
        end
        bus = '0;
        tick();
        chk("bad_sel_hold", cntx_value, 64'd3);

        // Write on the same edge as a pending hit.
        eventx_value = 64'd5;
        bus[4] = 1'b1;
        tick();
        bus = '0;
        wen = 1'b1;
        wdata = 64'h100;
        tick();
        chk("wr_wins", cntx_value, 64'h100);
        wen = 1'b0;
        tick();
        chk("wr_hold", cntx_value, 64'h100);

        // Inhibit rises with a second pulse; earlier hit still counts.
        bus[4] = 1'b1;
        tick();
        inh = 1'b1;
        tick();
        bus = '0;
        tick();
        inh = 1'b0;
        tick();
        tick();
        chk("inhibit_one", cntx_value, 64'h101);

        // Wrap, with a clear on the wrap edge.
        wen = 1'b1;
        wdata = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        wen = 1'b0;
        bus[4] = 1'b1;
        tick();
        tick();
        chk("pre_wrap", cntx_value, 64'hFFFF_FFFF_FFFF_FFFF);
        bus = '0;
        ovf_clr = 1'b1;
        tick();
        chk("wrap_zero", cntx_value, 64'd0);
`ifdef AQ_HPCP_OVF_EN
        chk("ovf_set_wins", {63'd0, cntx_ovf}, 64'd1);
`endif
        ovf_clr = 1'b0;
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        wen = 1'b1;
        wdata = 64'd0;
        tick();
        wen = 1'b0;
        tick();
`ifdef AQ_HPCP_OVF_EN
        chk("ovf_no_set_on_wr0", {63'd0, cntx_ovf}, 64'd0);
`endif

        // Reset while a hit is pending.
        wen = 1'b1;
        wdata = 64'h55;
        tick();
        wen = 1'b0;
        bus[4] = 1'b1;
        tick();
        chk("pre_rst", cntx_value, 64'h55);
        bus = '0;
        cpurst_b = 1'b0;
        #1;
        chk("rst_async", cntx_value, 64'd0);
        m_val  = 64'd0;
        m_hitq = 1'b0;
        m_ovf  = 1'b0;
        @(negedge eventx_clk);
        cpurst_b = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_no_inc", cntx_value, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_hpcp_cnt.md
# aq_hpcp_cnt

Per-counter increment stage of the hardware performance monitor, directly downstream of the event-selector register. Consumes the 64-bit event-select value and the global event bus, registers the selected event hit, and advances a 64-bit CSR-visible counter (mhpmcounterX). Also:
- Accepts CSR writes to the counter.
- Drives the clock-enable request for its own gated clock.
- Optionally flags counter wrap.

## Interface
Parameters:
- HPMCNT_NUM, 42, number of selectable events; valid select codes are 1..HPMCNT_NUM.
- HPMEVT_WIDTH, 6, number of select bits used from eventx_value.

Ports:
- eventx_clk  in  1  gated counter clock; the ICG enable is cntx_clk_en.
- cpurst_b  in  1  reset, asynchronous, active-low.
- eventx_value  in  64  event select; only [HPMEVT_WIDTH-1:0] is used, upper bits are ignored.
- hpcp_event_bus  in  HPMCNT_NUM  bit i-1 is a one-cycle pulse for event i.
- cntx_inhibit  in  1  mcountinhibit bit for this counter.
- cntx_wen  in  1  CSR write strobe for the counter.
- hpcp_wdata  in  64  CSR write data.
- cntx_ovf_clr  in  1  clears the overflow flag. Present only with the macro defined.
- cntx_value  out  64  current counter value.
- cntx_clk_en  out  1  combinational local_en request for the ICG feeding eventx_clk.
- cntx_ovf  out  1  sticky overflow flag. Present only with the macro defined.

## Operation
- Select decode: sel = eventx_value[HPMEVT_WIDTH-1:0].
  - hit_raw = hpcp_event_bus[sel-1] when 1 <= sel <= HPMCNT_NUM, else 0.
  - sel = 0 and sel > HPMCNT_NUM never count.
- Stage 1 register: hit_q <= hit_raw & ~cntx_inhibit & ~cntx_wen.
- Stage 2 counter, in priority order:
  1. cntx_wen: value <= hpcp_wdata[63:0].
  2. else hit_q: value <= value + 1, modulo 2^64.
  3. else hold.
- Write priority: a write and a pending hit_q in the same cycle leave value = wdata; that increment is dropped, not deferred.
- Inhibit:
  - Masks capture only at stage 1.
  - A hit_q already captured before inhibit rises still increments.
  - No count is lost or added at inhibit fall.
- Select change: applies to the next hit_raw sample; an in-flight hit_q still counts against the old event.
- Clock request: cntx_clk_en = hit_raw | hit_q | cntx_wen | cntx_ovf_clr. This keeps the clock running for every state change, including hit_q clearing.
- Wrap: increment from 0xFFFF_FFFF_FFFF_FFFF gives 0.
- Reset values: value = 0, hit_q = 0, cntx_ovf = 0. cntx_value = 0 in reset.

## Timing
- Event pulse sampled at edge N: cntx_value shows +1 after edge N+1, i.e. two-edge latency from bus to output.
- Consecutive event pulses on every cycle count once per cycle, with no bubbles.
- CSR write at edge N: cntx_value = wdata after edge N.
- A write at edge N also drops a hit_raw sampled at edge N; hit_q is forced to 0.
- cntx_clk_en is purely combinational from current inputs and hit_q, with no register stage.
- Reset asserted mid-operation: all state clears immediately. The first count after release needs a fresh event pulse.

## Configuration
- Macro: AQ_HPCP_OVF_EN.
- Defined:
  - cntx_ovf sets on the cycle the increment wraps to 0 and stays set until cntx_ovf_clr.
  - Set wins over a simultaneous clear.
  - A CSR write that loads 0 does not set the flag.
- Undefined: the cntx_ovf and cntx_ovf_clr ports and the flag register are removed, and cntx_clk_en omits the cntx_ovf_clr term.

## Test plan
- sel=5, bus[4] pulsed for 3 consecutive cycles from value 0 -> value=1,2,3 on successive edges, starting 2 edges after the first pulse.
- sel=0, then sel=43, with all bus bits toggling for 10 cycles -> value unchanged; cntx_clk_en low whenever wen=0 and hit_q=0.
- hit_q pending and cntx_wen with wdata=0x100 on the same edge -> value=0x100; the next edge holds 0x100.
- cntx_inhibit raised in the same cycle as one event pulse, with an earlier pulse already in hit_q -> exactly +1 total.
- value preloaded to 0xFFFF_FFFF_FFFF_FFFE, then 2 event pulses -> 0xFFFF_FFFF_FFFF_FFFF, then 0. With AQ_HPCP_OVF_EN, cntx_ovf=1 after the second increment and stays 1 when cntx_ovf_clr is asserted on that same wrap edge.
- cpurst_b pulsed low while hit_q=1 and value=0x55 -> value=0, no increment after release.
